// File: rtl/piso_counter_register.sv
// Parallel-in serial-out transmitter with a frame bit counter and last-bit carry-out.
// so is meant to drive the si input of the matching serial-in counter register.
module piso_counter_register #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_W     = 3,
    parameter bit          LSB_FIRST = 1'b0,
    parameter bit          IDLE_LVL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] pi,
    output logic             so,
    output logic [CNT_W-1:0] cnt,
    output logic             co,
    output logic             busy,
    output logic             rdy
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CntPen  = CNT_W'(WIDTH - 2);

    state_e             state_q;
    logic [WIDTH-1:0]   sreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               so_q;
    logic               co_q;
    logic               busy_q;

    logic [WIDTH-1:0]   sreg_adv;
    logic               first_pi;
    logic               first_adv;
    logic               at_last;
    logic               accept;

    // The bit on so is always the leading end of sreg_q, so advancing is a single shift.
    always_comb begin
        sreg_adv  = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
        first_pi  = LSB_FIRST ? pi[0] : pi[WIDTH-1];
        first_adv = LSB_FIRST ? sreg_adv[0] : sreg_adv[WIDTH-1];
        at_last   = (cnt_q == CntLast);
        accept    = ld && ((state_q == StIdle) || at_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            so_q    <= IDLE_LVL;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else if (en) begin
            if (accept) begin
                // Covers both a fresh load and a gapless reload on the last bit.
                state_q <= StShift;
                sreg_q  <= pi;
                cnt_q   <= '0;
                so_q    <= first_pi;
                co_q    <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                unique case (state_q)
                    StShift: begin
                        if (!at_last) begin
                            sreg_q <= sreg_adv;
                            so_q   <= first_adv;
                            cnt_q  <= cnt_q + CNT_W'(1);
                            co_q   <= (cnt_q == CntPen);
                        end else begin
                            state_q <= StIdle;
                            sreg_q  <= '0;
                            cnt_q   <= '0;
                            so_q    <= IDLE_LVL;
                            co_q    <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                    StIdle: begin
                        cnt_q  <= '0;
                        so_q   <= IDLE_LVL;
                        co_q   <= 1'b0;
                        busy_q <= 1'b0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign so   = so_q;
    assign cnt  = cnt_q;
    assign co   = co_q;
    assign busy = busy_q;
    assign rdy  = !busy_q || co_q;

endmodule

// File: tb/tb_piso_counter_register.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share stimulus; a monitor
// pops expected per-cycle frame records and also reassembles each received word.
module tb_piso_counter_register;

    localparam int W  = 8;
    localparam int CW = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         ld  = 1'b0;
    logic [W-1:0] pi  = '0;

    logic so_m, co_m, busy_m, rdy_m;
    logic so_l, co_l, busy_l, rdy_l;
    logic [CW-1:0] cnt_m, cnt_l;

    piso_counter_register #(.WIDTH(W), .CNT_W(CW), .LSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut_m (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .pi(pi),
        .so(so_m), .cnt(cnt_m), .co(co_m), .busy(busy_m), .rdy(rdy_m)
    );

    piso_counter_register #(.WIDTH(W), .CNT_W(CW), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1)) dut_l (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .pi(pi),
        .so(so_l), .cnt(cnt_l), .co(co_l), .busy(busy_l), .rdy(rdy_l)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          so_m;
        logic          so_l;
        logic [CW-1:0] cnt;
        logic          co;
        logic          busy;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] word_q[$];
    int           errors = 0;
    int           checks = 0;

    function automatic exp_t idle_rec();
        exp_t r;
        r.so_m = 1'b0;
        r.so_l = 1'b1;
        r.cnt  = '0;
        r.co   = 1'b0;
        r.busy = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: every enabled edge shows the next queued bit, or idle once the queue drains.
    initial begin
        exp_t         cur;
        logic [W-1:0] rx_m;
        logic [W-1:0] rx_l;
        logic [W-1:0] w;
        logic         en_s;
        logic         rst_s;
        cur  = idle_rec();
        rx_m = '0;
        rx_l = '0;
        forever begin
            @(posedge clk);
            en_s  = en;
            rst_s = rst;
            #1;
            if (rst_s) begin
                exp_q.delete();
                word_q.delete();
                cur = idle_rec();
            end else if (en_s) begin
                if (exp_q.size() > 0) begin
                    cur  = exp_q.pop_front();
                    rx_m = {rx_m[W-2:0], so_m};
                    rx_l = {so_l, rx_l[W-1:1]};
                    if (cur.co && word_q.size() > 0) begin
                        w = word_q.pop_front();
                        chk("rx_word_msb", 32'(rx_m), 32'(w));
                        chk("rx_word_lsb", 32'(rx_l), 32'(w));
                    end
                end else begin
                    cur = idle_rec();
                end
            end
            chk("so_msb", 32'(so_m), 32'(cur.so_m));
            chk("so_lsb", 32'(so_l), 32'(cur.so_l));
            chk("cnt_msb", 32'(cnt_m), 32'(cur.cnt));
            chk("cnt_lsb", 32'(cnt_l), 32'(cur.cnt));
            chk("co_msb", 32'(co_m), 32'(cur.co));
            chk("co_lsb", 32'(co_l), 32'(cur.co));
            chk("busy_msb", 32'(busy_m), 32'(cur.busy));
            chk("busy_lsb", 32'(busy_l), 32'(cur.busy));
            chk("rdy_msb", 32'(rdy_m), 32'(!cur.busy || cur.co));
            chk("rdy_lsb", 32'(rdy_l), 32'(!cur.busy || cur.co));
        end
    end

    // Drive one cycle; a load is accepted only when no frame bits remain to be shown.
    task automatic step(input logic e, input logic l, input logic [W-1:0] p, input logic r);
        exp_t rec;
        @(negedge clk);
        en  = e;
        ld  = l;
        pi  = p;
        rst = r;
        if (!r && e && l && exp_q.size() == 0) begin
            for (int i = 0; i < W; i++) begin
                rec.so_m = p[W-1-i];
                rec.so_l = p[i];
                rec.cnt  = CW'(i);
                rec.co   = (i == W - 1);
                rec.busy = 1'b1;
                exp_q.push_back(rec);
            end
            word_q.push_back(p);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        // Reset held two edges with load requested
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        idle(2);

        // Single frame
        step(1'b1, 1'b1, 8'hA5, 1'b0);
        idle(9);

        // Back-to-back reload on the last bit
        step(1'b1, 1'b1, 8'hA5, 1'b0);
        idle(7);
        step(1'b1, 1'b1, 8'h3C, 1'b0);
        idle(9);

        // Stall at cnt=3, then an ignored load at cnt=5
        step(1'b1, 1'b1, 8'hF0, 1'b0);
        idle(3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hFF, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        idle(4);

        // Mid-frame reset at cnt=4, then a clean frame
        step(1'b1, 1'b1, 8'hFF, 1'b0);
        idle(4);
        step(1'b1, 1'b1, 8'h00, 1'b1);
        idle(3);
        step(1'b1, 1'b1, 8'h81, 1'b0);
        idle(9);

        // Frames that matter for the LSB-first instance and loopback
        step(1'b1, 1'b1, 8'h01, 1'b0);
        idle(9);
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        idle(9);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 8), ($urandom_range(0, 3) == 0), W'($urandom),
                 ($urandom_range(0, 149) == 0));
        end
        idle(12);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
